// File: rtl/hex_display_pkg.sv
// Shared constants for the hex seven-segment display controller:
// active-low glyph table, blank code and parameter legality helpers.
package hex_display_pkg;

   // Active-low segment code for a fully dark digit.
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low glyphs for nibble values 0..F, bit order g..a = [6:0].
   localparam logic [6:0] SEG_HEX [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
   };

   // Digit count must stay within what one 32-bit word can hold.
   function automatic bit num_digits_legal(input int n);
      return (n >= 1) && (n <= 8);
   endfunction

   // Divider values are hold lengths in clocks, so zero is meaningless.
   function automatic bit div_legal(input int d);
      return d >= 1;
   endfunction

   // Bits needed for a counter running 0..d-1, never narrower than one bit.
   function automatic int cnt_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/hex_seg_encode.sv
// One hex digit to active-low seven-segment code, with a forced-blank input.
module hex_seg_encode
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   // Table lookup unless the digit is being suppressed.
   always_comb begin
      seg = SEG_OFF;
      if (blank) begin
         seg = SEG_OFF;
      end else begin
         seg = SEG_HEX[nibble];
      end
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex display controller: shadow register, leading-zero blanking,
// whole-display blink, static per-digit buses and a scanned mux bus.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 12500000
)
(
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      blank_lz,
   input  logic                      blink_en,
   output logic [7*NUM_DIGITS-1:0]   seg_static,
   output logic [6:0]                seg_mux,
   output logic [NUM_DIGITS-1:0]     an_mux,
   output logic                      updated
);

   localparam int DATA_W  = 4 * NUM_DIGITS;
   localparam int SEG_W   = 7 * NUM_DIGITS;
   localparam int IDX_W   = cnt_width(NUM_DIGITS);
   localparam int SCAN_W  = cnt_width(SCAN_DIV);
   localparam int BLINK_W = cnt_width(BLINK_DIV);

   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   if (!num_digits_legal(NUM_DIGITS) || !div_legal(SCAN_DIV) || !div_legal(BLINK_DIV)) begin : g_param_check
      $error("hex_display_ctrl: illegal NUM_DIGITS, SCAN_DIV or BLINK_DIV");
   end

   logic [DATA_W-1:0]  shadow_q,     shadow_d;
   logic               loaded_q,     loaded_d;
   logic               updated_q,    updated_d;
   logic [SEG_W-1:0]   seg_static_q, seg_static_d;
   logic [6:0]         seg_mux_q,    seg_mux_d;
   logic [NUM_DIGITS-1:0] an_mux_q,  an_mux_d;
   logic [IDX_W-1:0]   scan_idx_q,   scan_idx_d;
   logic [SCAN_W-1:0]  scan_cnt_q,   scan_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q,  blink_cnt_d;
   logic               blink_dark_q, blink_dark_d;

   logic [NUM_DIGITS-1:0] blank_s;
   logic                  lz_run_s;
   logic [6:0]            enc_s [NUM_DIGITS];
   logic [6:0]            vis_s [NUM_DIGITS];

   // Walk from the most significant digit down, blanking while every digit so far is zero.
   always_comb begin
      blank_s  = '0;
      lz_run_s = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run_s = lz_run_s & (shadow_q[4*i +: 4] == 4'h0);
         if (blank_lz) begin
            blank_s[i] = lz_run_s;
         end else begin
            blank_s[i] = 1'b0;
         end
      end
      // Digit 0 always shows, so a zero word reads "0" rather than nothing.
      blank_s[0] = 1'b0;
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      hex_seg_encode u_enc (
         .nibble (shadow_q[4*g +: 4]),
         .blank  (blank_s[g]),
         .seg    (enc_s[g])
      );
   end

   // Apply the blink mask, then build the static bus and the scanned digit/anode pair.
   always_comb begin
      seg_static_d = '1;
      an_mux_d     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (blink_en && blink_dark_q) begin
            vis_s[i] = SEG_OFF;
         end else begin
            vis_s[i] = enc_s[i];
         end
         seg_static_d[7*i +: 7] = vis_s[i];
         if (scan_idx_q == IDX_W'(i)) begin
            an_mux_d[i] = 1'b0;
         end else begin
            an_mux_d[i] = 1'b1;
         end
      end
      // Anode and segments come from the same index, so they switch on the same edge.
      seg_mux_d = vis_s[scan_idx_q];
   end

   // Shadow capture and the one-cycle-delayed update flag.
   always_comb begin
      shadow_d  = shadow_q;
      if (load) begin
         shadow_d = value;
      end else begin
         shadow_d = shadow_q;
      end
      loaded_d  = load;
      updated_d = loaded_q;
   end

   // Free-running scan prescaler and digit index, plus blink prescaler and phase.
   always_comb begin
      scan_cnt_d   = scan_cnt_q;
      scan_idx_d   = scan_idx_q;
      blink_cnt_d  = blink_cnt_q;
      blink_dark_d = blink_dark_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         if (scan_idx_q == IDX_LAST) begin
            scan_idx_d = '0;
         end else begin
            scan_idx_d = scan_idx_q + 1'b1;
         end
      end else begin
         scan_cnt_d = scan_cnt_q + 1'b1;
      end
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d  = '0;
         blink_dark_d = ~blink_dark_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // State update with synchronous reset taking priority over load and counters.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         shadow_q     <= '0;
         loaded_q     <= 1'b0;
         updated_q    <= 1'b0;
         seg_static_q <= {NUM_DIGITS{SEG_OFF}};
         seg_mux_q    <= SEG_OFF;
         an_mux_q     <= '1;
         scan_idx_q   <= '0;
         scan_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         blink_dark_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         loaded_q     <= loaded_d;
         updated_q    <= updated_d;
         seg_static_q <= seg_static_d;
         seg_mux_q    <= seg_mux_d;
         an_mux_q     <= an_mux_d;
         scan_idx_q   <= scan_idx_d;
         scan_cnt_q   <= scan_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_dark_q <= blink_dark_d;
      end
   end

   assign seg_static = seg_static_q;
   assign seg_mux    = seg_mux_q;
   assign an_mux     = an_mux_q;
   assign updated    = updated_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (4 digits, scan 4, blink 8).
// The driver predicts each cycle's outputs from a word-level model and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_hex_display_ctrl;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BD = 8;

   typedef struct packed {
      logic [7*ND-1:0] ss;
      logic [6:0]      sm;
      logic [ND-1:0]   an;
      logic            up;
   } exp_t;

   logic              Clk;
   logic              Rst;
   logic              load;
   logic [4*ND-1:0]   value;
   logic              blank_lz;
   logic              blink_en;
   logic [7*ND-1:0]   seg_static;
   logic [6:0]        seg_mux;
   logic [ND-1:0]     an_mux;
   logic              updated;

   hex_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .load       (load),
      .value      (value),
      .blank_lz   (blank_lz),
      .blink_en   (blink_en),
      .seg_static (seg_static),
      .seg_mux    (seg_mux),
      .an_mux     (an_mux),
      .updated    (updated)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference glyphs, written out independently of the design package.
   logic [6:0] glyph [16];
   initial begin
      glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
      glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
      glyph[8]  = 7'h00; glyph[9]  = 7'h18; glyph[10] = 7'h08; glyph[11] = 7'h03;
      glyph[12] = 7'h27; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
   end

   exp_t exp_q [$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Model state: displayed word, clocks since reset, load seen on previous edge.
   logic [4*ND-1:0] m_word  = '0;
   int              m_edges = 0;
   logic            m_prev_load = 1'b0;

   // Predict outputs after the coming edge for the given inputs, then advance the model.
   task automatic step(input logic rst, input logic ld, input logic [4*ND-1:0] val,
                       input logic blz, input logic ben);
      exp_t e;
      int   idx;
      bit   dark;
      logic [3:0] nib;
      Rst = rst; load = ld; value = val; blank_lz = blz; blink_en = ben;
      if (rst) begin
         e.ss = {ND{7'h7F}};
         e.sm = 7'h7F;
         e.an = '1;
         e.up = 1'b0;
         m_word = '0;
         m_edges = 0;
         m_prev_load = 1'b0;
      end else begin
         idx  = (m_edges / SD) % ND;
         dark = ((m_edges / BD) % 2) == 1;
         for (int i = 0; i < ND; i++) begin
            nib = m_word[4*i +: 4];
            if ((ben && dark) || (blz && i != 0 && (m_word >> (4*i)) == 0))
               e.ss[7*i +: 7] = 7'h7F;
            else
               e.ss[7*i +: 7] = glyph[nib];
         end
         e.sm = e.ss[7*idx +: 7];
         e.an = ~(4'b0001 << idx);
         e.up = m_prev_load;
         if (ld) m_word = val;
         m_prev_load = ld;
         m_edges++;
      end
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   // Scoreboard monitor: one comparison per clock, away from the active edge.
   always @(negedge Clk) begin
      exp_t e;
      cyc++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({seg_static, seg_mux, an_mux, updated} !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got ss=%h sm=%h an=%b up=%b, expected ss=%h sm=%h an=%b up=%b",
                     cyc, seg_static, seg_mux, an_mux, updated, e.ss, e.sm, e.an, e.up);
         end
      end
   end

   logic [4*ND-1:0] rv;
   logic [4*ND-1:0] masks [5];
   logic            r_blz, r_ben;

   initial begin
      masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
      masks[3] = 16'h000F; masks[4] = 16'h0000;
      Rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = 1'b0;

      // Reset, then the post-reset zero display.
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Load 12AF, then watch a full scan rotation and back.
      step(1'b0, 1'b1, 16'h12AF, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Back-to-back loads keep updated high.
      step(1'b0, 1'b1, 16'h3456, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h789B, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Leading-zero blanking cases.
      step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Blink from reset, with a load during the first dark phase.
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 16'hC0DE, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      // Reset together with a load while the scan index is 2.
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      // Randomised traffic.
      r_blz = 1'b0; r_ben = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rv = 16'($urandom) & masks[$urandom_range(0, 4)];
         if ($urandom_range(0, 15) == 0) r_blz = ~r_blz;
         if ($urandom_range(0, 23) == 0) r_ben = ~r_ben;
         step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0), rv, r_blz, r_ben);
      end
      step(1'b0, 1'b0, 16'h0, r_blz, r_ben);

      @(negedge Clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised N-digit hexadecimal seven-segment display controller. It replaces the fixed four-digit combinational decode used on board tops.
- Captures a data word into a shadow register on a load strobe.
- Drives static per-digit segment buses and a time-multiplexed scan bus (one segment bus plus digit anodes).
- Adds optional leading-zero blanking and whole-display blinking.
- Sits between the datapath result register (e.g. Rdest) and the board's HEX/anode pins.

Parameters:
NUM_DIGITS, 4, number of hex digits; legal 1..8; data width = 4*NUM_DIGITS
SCAN_DIV, 50000, clocks each digit is held active in scan mode; legal >=1
BLINK_DIV, 12500000, clocks per blink half-period; legal >=1

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  synchronous active-high reset
load  input  1  capture strobe; value sampled on the edge where load=1
value  input  4*NUM_DIGITS  data word; digit i = value[4i+3:4i]; digit 0 is least significant
blank_lz  input  1  1 = blank leading zero digits
blink_en  input  1  1 = blink whole display
seg_static  output  7*NUM_DIGITS  active-low segments, digit i at [7i+6:7i]; bit order g..a = [6:0]
seg_mux  output  7  active-low segments of the currently scanned digit
an_mux  output  NUM_DIGITS  active-low one-hot digit enable
updated  output  1  one-cycle pulse when seg_static first reflects a newly loaded value

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high. Rst has priority over load and over all counters.
- Reset values:
  - shadow register = 0
  - seg_static = all 7'h7F (off)
  - seg_mux = 7'h7F
  - an_mux = all ones
  - updated = 0
  - scan index = 0, scan prescaler = 0
  - blink counter = 0, blink phase = visible
- Capture: load=1 at edge k writes value into the shadow register at k. seg_static shows the new value from edge k+1, and updated=1 for exactly that cycle. Back-to-back loads are each captured; updated stays high while consecutive loads continue.
- Latency: changes on blank_lz and blink_en take effect with 1 cycle of latency, through the registered outputs.
- Encoding: active-low, taken from the package table:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, B=03, C=27, D=21, E=06, F=0E (hex)
- Leading-zero blanking (blank_lz=1): digit i is forced to 7'h7F when it and every more significant digit are 0. Digit 0 is never blanked, so value 0 displays "0".
- Blink:
  - The blink counter runs 0..BLINK_DIV-1 continuously, regardless of blink_en. On its terminal count the phase toggles.
  - When blink_en=1 and phase=dark, seg_static and seg_mux are all 7'h7F.
  - an_mux keeps scanning during the dark phase.
  - Loads during the dark phase are captured normally; updated still pulses.
- Scan:
  - The prescaler runs 0..SCAN_DIV-1. On its terminal count the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - an_mux = ~(1<<index).
  - seg_mux = the post-blanking, post-blink segments of digit index.
  - an_mux and seg_mux are registered and change on the same edge, so there are no ghost cycles.
  - When NUM_DIGITS=1, an_mux stays permanently 0.
- Reset mid-operation: all state returns to the reset values on the next edge; any in-flight load is discarded.

Decomposition:
- Package hex_display_pkg: SEG_HEX[0:15] table, SEG_OFF=7'h7F, legality checks for the parameters.
- Sub-module hex_seg_encode: combinational, nibble plus blank input to a 7-bit active-low code; instantiated NUM_DIGITS times via generate.
- Counters, shadow register, blanking chain and scan mux stay in hex_display_ctrl.

Test Plan:
Bench configuration: NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
1. Rst=1 for 2 cycles -> seg_static=all 7F, an_mux=4'hF, updated=0. One cycle after release -> seg_static digits all 7'h40.
2. load=1 with value 16'h12AF -> next cycle seg_static d3..d0 = 79,24,08,0E and updated=1 for one cycle only.
3. blank_lz=1, load 16'h0030 -> d3=7F, d2=7F, d1=30, d0=40. Load 16'h0000 -> d3..d1=7F, d0=40. Load 16'h0100 -> d3=7F, d2=79, d1=40, d0=40.
4. Scan after 16'h12AF -> an_mux sequence 1110,1101,1011,0111,1110, each held 4 cycles. seg_mux = 0E,08,24,79 respectively, changing on the same edge as an_mux.
5. blink_en=1 from reset -> segments visible for 8 cycles, then all 7F for 8 cycles, repeating. an_mux keeps scanning. A load during the dark phase is shown at the next visible phase.
6. Rst asserted together with load while scan index=2 -> next cycle matches the reset values (index 0, shadow register 0); the load value is never displayed.
